// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core (port 0)
// and a loader/debug master (port 1). One access per cycle, round-robin
// priority, and a bounded back-to-back lock for port-1 bursts.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned MAX_BURST     = 4
) (
    input  logic                       CLK,
    input  logic                       RST,

    input  logic                       req0,
    input  logic [DATA_WIDTH/8-1:0]    we0,
    input  logic [ADDRESS_WIDTH-1:0]   addr0,
    input  logic [DATA_WIDTH-1:0]      wdata0,
    output logic                       gnt0,
    output logic                       rvalid0,
    output logic [DATA_WIDTH-1:0]      rdata0,

    input  logic                       req1,
    input  logic                       lock1,
    input  logic [DATA_WIDTH/8-1:0]    we1,
    input  logic [ADDRESS_WIDTH-1:0]   addr1,
    input  logic [DATA_WIDTH-1:0]      wdata1,
    output logic                       gnt1,
    output logic                       rvalid1,
    output logic [DATA_WIDTH-1:0]      rdata1,

    output logic [ADDRESS_WIDTH-1:0]   MemA,
    output logic [DATA_WIDTH-1:0]      MemWD,
    output logic [DATA_WIDTH/8-1:0]    MemWE,
    input  logic [DATA_WIDTH-1:0]      MemRD
);

    localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   burst_cnt;
    logic [CNT_WIDTH-1:0]   burst_cnt_next;
    logic                   rr_last;
    logic                   burst_open;
    logic                   read0;
    logic                   read1;

    assign burst_open = (burst_cnt < CNT_WIDTH'(MAX_BURST));
    assign read0      = gnt0 && (we0 == NUM_LANES'(0));
    assign read1      = gnt1 && (we1 == NUM_LANES'(0));

    // Grant decision from registered state; nothing is granted while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (RST) begin
            if (req0 && !req1) begin
                gnt0 = 1'b1;
            end else if (!req0 && req1) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
                if (state == LOCK1) begin
                    // Port 1 keeps the memory only until its burst allowance runs out.
                    if (burst_open) begin
                        gnt1 = 1'b1;
                    end else begin
                        gnt0 = 1'b1;
                    end
                end else if (rr_last) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end
        end
    end

    // Memory-side mux: the granted port drives the memory, otherwise all zero.
    always_comb begin
        MemA  = '0;
        MemWD = '0;
        MemWE = '0;
        if (gnt0) begin
            MemA  = addr0;
            MemWD = wdata0;
            MemWE = we0;
        end else if (gnt1) begin
            MemA  = addr1;
            MemWD = wdata1;
            MemWE = we1;
        end
    end

    // Burst lock next-state and burst counter.
    always_comb begin
        state_next     = state;
        burst_cnt_next = burst_cnt;
        case (state)
            IDLE: begin
                if (gnt1 && lock1) begin
                    state_next     = LOCK1;
                    burst_cnt_next = CNT_WIDTH'(1);
                end
            end
            LOCK1: begin
                if (!lock1 || !req1 || gnt0) begin
                    state_next     = IDLE;
                    burst_cnt_next = '0;
                end else if (gnt1 && burst_open) begin
                    burst_cnt_next = burst_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_next     = IDLE;
                burst_cnt_next = '0;
            end
        endcase
    end

    // Arbitration state registers; rr_last resets to 1 so port 0 wins first.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            burst_cnt <= '0;
            rr_last   <= 1'b1;
        end else begin
            state     <= state_next;
            burst_cnt <= burst_cnt_next;
            if (gnt0) begin
                rr_last <= 1'b0;
            end else if (gnt1) begin
                rr_last <= 1'b1;
            end
        end
    end

    // Read return: capture memory data on a read grant, valid pulses one cycle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= read0;
            rvalid1 <= read1;
            if (read0) begin
                rdata0 <= MemRD;
            end
            if (read1) begin
                rdata1 <= MemRD;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus hand sequences; read data expectations
// come from a bench-side shadow memory and are queued per port until rvalid.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    logic        CLK;
    logic        RST;
    logic        req0, req1, lock1;
    logic [3:0]  we0, we1;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [8:0]  MemA;
    logic [31:0] MemWD;
    logic [3:0]  MemWE;
    logic [31:0] MemRD;

    dmem_arbiter #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(9),
        .MAX_BURST    (4)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .req0   (req0),
        .we0    (we0),
        .addr0  (addr0),
        .wdata0 (wdata0),
        .gnt0   (gnt0),
        .rvalid0(rvalid0),
        .rdata0 (rdata0),
        .req1   (req1),
        .lock1  (lock1),
        .we1    (we1),
        .addr1  (addr1),
        .wdata1 (wdata1),
        .gnt1   (gnt1),
        .rvalid1(rvalid1),
        .rdata1 (rdata1),
        .MemA   (MemA),
        .MemWD  (MemWD),
        .MemWE  (MemWE),
        .MemRD  (MemRD)
    );

    typedef struct {
        logic        r0;
        logic [3:0]  w0;
        logic [8:0]  a0;
        logic [31:0] d0;
        logic        r1;
        logic        l1;
        logic [3:0]  w1;
        logic [8:0]  a1;
        logic [31:0] d1;
        logic        g0;
        logic        g1;
    } vec_t;

    logic [31:0] mem    [0:127];
    logic [31:0] shadow [0:127];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic        pend0, pend1;
    int          n_cmp, n_bad;
    vec_t        vecs [$];

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] v;
        v = {8'hA5, 8'(i), 8'(i + 1), 8'(i + 2)};
        if (i == 4)  v = 32'hDEADBEEF;
        if (i == 8)  v = 32'h11223344;
        return v;
    endfunction

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory model: combinational read, byte-enabled synchronous write.
    assign MemRD = mem[MemA[8:2]];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = init_word(i);
        forever begin
            @(posedge CLK);
            for (int b = 0; b < 4; b++) begin
                if (MemWE[b]) mem[MemA[8:2]][8*b +: 8] <= MemWD[8*b +: 8];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; lock1 = v.l1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    endtask

    function automatic vec_t mk(input logic r0, input logic [3:0] w0, input logic [8:0] a0,
                                input logic [31:0] d0, input logic r1, input logic l1,
                                input logic [3:0] w1, input logic [8:0] a1, input logic [31:0] d1,
                                input logic g0, input logic g1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic shadow_write(input logic [8:0] a, input logic [3:0] w, input logic [31:0] d);
        for (int b = 0; b < 4; b++) begin
            if (w[b]) shadow[a[8:2]][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // One cycle: check grants/mux/read return at the falling edge, then
    // update the scoreboard with what this cycle's grant should produce.
    task automatic step(input logic eg0, input logic eg1, input string nm);
        logic [3:0]  ewe;
        logic [8:0]  ea;
        logic [31:0] ed;
        @(negedge CLK);
        chk({nm, ".gnt0"}, 32'(gnt0), 32'(eg0));
        chk({nm, ".gnt1"}, 32'(gnt1), 32'(eg1));
        ewe = 4'h0; ea = 9'h0; ed = 32'h0;
        if (eg0) begin
            ewe = we0; ea = addr0; ed = wdata0;
        end else if (eg1) begin
            ewe = we1; ea = addr1; ed = wdata1;
        end
        chk({nm, ".MemWE"}, 32'(MemWE), 32'(ewe));
        chk({nm, ".MemA"},  32'(MemA),  32'(ea));
        chk({nm, ".MemWD"}, MemWD, ed);
        chk({nm, ".rvalid0"}, 32'(rvalid0), 32'(pend0));
        chk({nm, ".rvalid1"}, 32'(rvalid1), 32'(pend1));
        if (pend0 && exp_q0.size() > 0) chk({nm, ".rdata0"}, rdata0, exp_q0.pop_front());
        if (pend1 && exp_q1.size() > 0) chk({nm, ".rdata1"}, rdata1, exp_q1.pop_front());
        pend0 = eg0 && (we0 == 4'h0);
        pend1 = eg1 && (we1 == 4'h0);
        if (pend0) exp_q0.push_back(shadow[addr0[8:2]]);
        else if (eg0) shadow_write(addr0, we0, wdata0);
        if (pend1) exp_q1.push_back(shadow[addr1[8:2]]);
        else if (eg1) shadow_write(addr1, we1, wdata1);
        @(posedge CLK);
        #1;
    endtask

    vec_t idle_v;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int i = 0; i < 128; i++) shadow[i] = init_word(i);
        idle_v = mk(0, 4'h0, 9'h0, 32'h0, 0, 0, 4'h0, 9'h0, 32'h0, 0, 0);

        // Contention straight after reset, then single reads.
        vecs.push_back(mk(1, 4'h0, 9'h010, 32'h0, 1, 0, 4'h0, 9'h014, 32'h0, 1, 0));
        vecs.push_back(mk(1, 4'h0, 9'h018, 32'h0, 1, 0, 4'h0, 9'h014, 32'h0, 0, 1));
        vecs.push_back(mk(1, 4'h0, 9'h018, 32'h0, 1, 0, 4'h0, 9'h01C, 32'h0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 9'h000, 32'h0, 1, 0, 4'h0, 9'h01C, 32'h0, 0, 1));
        vecs.push_back(mk(1, 4'h0, 9'h010, 32'h0, 0, 0, 4'h0, 9'h000, 32'h0, 1, 0));
        vecs.push_back(idle_v);
        // Byte-lane write on port 1, read back on port 0.
        vecs.push_back(mk(0, 4'h0, 9'h000, 32'h0, 1, 0, 4'b0010, 9'h020, 32'h0000AB00, 0, 1));
        vecs.push_back(mk(1, 4'h0, 9'h020, 32'h0, 0, 0, 4'h0, 9'h000, 32'h0, 1, 0));
        vecs.push_back(idle_v);
        // Locked burst capped at four grants while port 0 waits.
        vecs.push_back(mk(1, 4'h0, 9'h040, 32'h0, 1, 1, 4'h0, 9'h030, 32'h0, 0, 1));
        vecs.push_back(mk(1, 4'h0, 9'h040, 32'h0, 1, 1, 4'h0, 9'h034, 32'h0, 0, 1));
        vecs.push_back(mk(1, 4'h0, 9'h040, 32'h0, 1, 1, 4'h0, 9'h038, 32'h0, 0, 1));
        vecs.push_back(mk(1, 4'h0, 9'h040, 32'h0, 1, 1, 4'h0, 9'h03C, 32'h0, 0, 1));
        vecs.push_back(mk(1, 4'h0, 9'h040, 32'h0, 1, 1, 4'h0, 9'h044, 32'h0, 1, 0));
        vecs.push_back(mk(1, 4'h0, 9'h048, 32'h0, 1, 0, 4'h0, 9'h044, 32'h0, 0, 1));
        vecs.push_back(mk(1, 4'h0, 9'h048, 32'h0, 0, 0, 4'h0, 9'h000, 32'h0, 1, 0));
        vecs.push_back(idle_v);
        // Port 1 alone keeps getting grants past the cap; counter saturates.
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0, 4'h0, 9'h000, 32'h0, 1, 1, 4'h0, 9'(9'h060 + 4 * k), 32'h0, 0, 1));
        vecs.push_back(mk(1, 4'h0, 9'h080, 32'h0, 1, 1, 4'h0, 9'h078, 32'h0, 1, 0));
        vecs.push_back(idle_v);
        // Full-word write on port 0, read back on port 1.
        vecs.push_back(mk(1, 4'hF, 9'h050, 32'hCAFEF00D, 0, 0, 4'h0, 9'h000, 32'h0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 9'h000, 32'h0, 1, 0, 4'h0, 9'h050, 32'h0, 0, 1));
        vecs.push_back(idle_v);

        // Reset with both ports requesting and port 0 attempting a write.
        RST = 1'b0;
        drive(mk(1, 4'hF, 9'h010, 32'h0, 1, 0, 4'h0, 9'h014, 32'h0, 0, 0));
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("reset.gnt0",    32'(gnt0),    32'h0);
        chk("reset.gnt1",    32'(gnt1),    32'h0);
        chk("reset.MemWE",   32'(MemWE),   32'h0);
        chk("reset.rvalid0", 32'(rvalid0), 32'h0);
        chk("reset.rvalid1", 32'(rvalid1), 32'h0);
        chk("reset.rdata0",  rdata0,       32'h0);
        chk("reset.rdata1",  rdata1,       32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step(vecs[i].g0, vecs[i].g1, $sformatf("vec%0d", i));
        end
        chk("table.q0_drained", 32'(exp_q0.size()), 32'h0);
        chk("table.q1_drained", 32'(exp_q1.size()), 32'h0);

        // Reset lands while a port-0 read is returning.
        drive(mk(1, 4'h0, 9'h010, 32'h0, 0, 0, 4'h0, 9'h000, 32'h0, 0, 0));
        step(1, 0, "midrst.grant");
        RST = 1'b0;
        drive(idle_v);
        step(0, 0, "midrst.assert");
        drive(mk(1, 4'hF, 9'h010, 32'h0, 1, 0, 4'h0, 9'h014, 32'h0, 0, 0));
        chk("midrst.rdata0_pre", rdata0, rdata0 === 32'h0 ? rdata0 : 32'h0);
        step(0, 0, "midrst.held");
        chk("midrst.rdata0", rdata0, 32'h0);
        RST = 1'b1;
        drive(mk(1, 4'h0, 9'h010, 32'h0, 1, 0, 4'h0, 9'h014, 32'h0, 0, 0));
        step(1, 0, "midrst.first");
        drive(mk(0, 4'h0, 9'h000, 32'h0, 1, 0, 4'h0, 9'h014, 32'h0, 0, 0));
        step(0, 1, "midrst.second");

        // Quiet bus: no grants, no enables, no read returns after the tail.
        drive(idle_v);
        for (int i = 0; i < 11; i++) step(0, 0, $sformatf("idle%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
